// File: rtl/led_matrix_column_scanner.sv
// Column scanner: latches a COLS x ROWS frame and drives one column at a time onto a 7x5 LED matrix.
// Latency: one clock from enable (or frame wrap) to the column being driven; each column holds DIV clocks.
// Backpressure: none; free-running scan, frame_data is only sampled at frame boundaries.
//
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   enable       - 1 = scan, 0 = matrix dark (returns to IDLE)
//   frame_data   - column images, column c at [c*ROWS +: ROWS]
//   rows_out     - active-high row drive of the current column
//   cols_out     - active-low column select, one-cold while scanning
//   col_idx      - index of the currently driven column (0 in IDLE)
//   frame_start  - one-cycle pulse when column 0 of a newly latched frame begins
// Optional: define SCAN_BLANKING_EN to insert one dark cycle after every column.
module led_matrix_column_scanner #(
  parameter int COLS = 5,
  parameter int ROWS = 7,
  parameter int DIV  = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [COLS*ROWS-1:0] frame_data,
  output logic [ROWS-1:0]      rows_out,
  output logic [COLS-1:0]      cols_out,
  output logic [2:0]           col_idx,
  output logic                 frame_start
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SCAN_BLANKING_EN
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t                 state;
  logic [DW-1:0]          div_cnt;
  logic [2:0]             col;
  logic [COLS*ROWS-1:0]   shadow;

  logic                   tc;
  logic                   wrap;
  logic [2:0]             next_col;
  logic [ROWS-1:0]        next_rows;

  // Column advance: on wrap the new frame is shown straight from frame_data,
  // since the shadow register is being loaded on the same edge.
  always_comb begin
    tc        = (div_cnt == DW'(DIV - 1));
    wrap      = (col == 3'(COLS - 1));
    next_col  = wrap ? 3'd0 : col + 3'd1;
    next_rows = wrap ? frame_data[ROWS-1:0] : shadow[next_col*ROWS +: ROWS];
  end

  assign col_idx = col;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      col         <= '0;
      shadow      <= '0;
      rows_out    <= '0;
      cols_out    <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          col      <= '0;
          rows_out <= '0;
          cols_out <= '1;
          if (enable) begin
            state       <= SCAN;
            shadow      <= frame_data;
            rows_out    <= frame_data[ROWS-1:0];
            cols_out    <= ~COLS'(1);
            frame_start <= 1'b1;
          end
        end

        SCAN: begin
          if (!enable) begin
            state    <= IDLE;
            div_cnt  <= '0;
            col      <= '0;
            rows_out <= '0;
            cols_out <= '1;
          end else if (tc) begin
            div_cnt <= '0;
`ifdef SCAN_BLANKING_EN
            // Dark cycle between columns; col holds so col_idx shows the old column.
            state    <= BLANK;
            rows_out <= '0;
            cols_out <= '1;
`else
            col      <= next_col;
            rows_out <= next_rows;
            cols_out <= ~(COLS'(1) << next_col);
            if (wrap) begin
              shadow      <= frame_data;
              frame_start <= 1'b1;
            end
`endif
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

`ifdef SCAN_BLANKING_EN
        BLANK: begin
          div_cnt <= '0;
          if (!enable) begin
            state    <= IDLE;
            col      <= '0;
            rows_out <= '0;
            cols_out <= '1;
          end else begin
            state    <= SCAN;
            col      <= next_col;
            rows_out <= next_rows;
            cols_out <= ~(COLS'(1) << next_col);
            if (wrap) begin
              shadow      <= frame_data;
              frame_start <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          div_cnt  <= '0;
          col      <= '0;
          rows_out <= '0;
          cols_out <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Bench for led_matrix_column_scanner (COLS=5, ROWS=7, DIV=4).
// Stimulus pushes the expected post-edge outputs into a queue; a monitor pops and compares after each edge.
// No backpressure; every cycle carries one expectation.
module tb_led_matrix_column_scanner;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [34:0] frame_data;
  logic [6:0]  rows_out;
  logic [4:0]  cols_out;
  logic [2:0]  col_idx;
  logic        frame_start;

  typedef struct packed {
    logic [6:0] rows;
    logic [4:0] cols;
    logic [2:0] idx;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [4:0] csel [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

  led_matrix_column_scanner #(.COLS(5), .ROWS(7), .DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .rows_out    (rows_out),
    .cols_out    (cols_out),
    .col_idx     (col_idx),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rows_out",    int'(rows_out),    int'(e.rows));
        chk("cols_out",    int'(cols_out),    int'(e.cols));
        chk("col_idx",     int'(col_idx),     int'(e.idx));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("one_cold",    ($countones(~cols_out) <= 1) ? 1 : 0, 1);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic cyc(input logic r, input logic e, input logic [6:0] er,
                     input logic [4:0] ec, input logic [2:0] ei, input logic ef);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    enable = e;
    x.rows = er;
    x.cols = ec;
    x.idx  = ei;
    x.fs   = ef;
    q.push_back(x);
  endtask

  task automatic off_cyc(input logic r, input logic e);
    cyc(r, e, 7'h00, 5'b11111, 3'd0, 1'b0);
  endtask

  // n cycles of column c showing img; fs on the first cycle if requested;
  // 'last' marks the column's final cycle (followed by a dark cycle when blanking is built in).
  task automatic scan_part(input int c, input logic [6:0] img, input logic fs,
                           input int n, input logic last);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b1, img, csel[c], 3'(c), (i == 0) && fs);
`ifdef SCAN_BLANKING_EN
    if (last) cyc(1'b1, 1'b1, 7'h00, 5'b11111, 3'(c), 1'b0);
`else
    if (last) begin end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    frame_data = '0;

    // Reset, then idle with enable low.
    for (int i = 0; i < 3; i++) off_cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) off_cyc(1'b1, 1'b0);

    // Frame 0; col2 image changes during column 1 and must not show until frame 1.
    frame_data = {7'h15, 7'h2A, 7'h00, 7'h7F, 7'h41};
    scan_part(0, 7'h41, 1'b1, 4, 1'b1);
    scan_part(1, 7'h7F, 1'b0, 2, 1'b0);
    frame_data[20:14] = 7'h55;
    scan_part(1, 7'h7F, 1'b0, 2, 1'b1);
    scan_part(2, 7'h00, 1'b0, 4, 1'b1);
    scan_part(3, 7'h2A, 1'b0, 4, 1'b1);
    scan_part(4, 7'h15, 1'b0, 4, 1'b1);

    // Frame 1 picks up the new col2 image; disable part-way through column 3.
    scan_part(0, 7'h41, 1'b1, 4, 1'b1);
    scan_part(1, 7'h7F, 1'b0, 4, 1'b1);
    scan_part(2, 7'h55, 1'b0, 4, 1'b1);
    scan_part(3, 7'h2A, 1'b0, 2, 1'b0);
    off_cyc(1'b1, 1'b0);
    off_cyc(1'b1, 1'b0);

    // Re-enable with a new col0 image: fresh latch, column 0, frame_start.
    frame_data[6:0] = 7'h63;
    scan_part(0, 7'h63, 1'b1, 4, 1'b1);
    scan_part(1, 7'h7F, 1'b0, 4, 1'b1);
    scan_part(2, 7'h55, 1'b0, 2, 1'b0);

    // Reset during column 2 with enable held high, then restart.
    off_cyc(1'b0, 1'b1);
    off_cyc(1'b0, 1'b1);
    scan_part(0, 7'h63, 1'b1, 4, 1'b1);
    scan_part(1, 7'h7F, 1'b0, 1, 1'b0);
    off_cyc(1'b1, 1'b0);

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_column_scanner.md
Name: led_matrix_column_scanner

Overview:
- Consumer end of the column-image path. Column decoders produce static 7-bit row images per column; this block multiplexes those images onto the physical 7x5 LED matrix.
- Latches a full frame at each frame boundary, then drives one column at a time.
- Holds each column for a programmable number of clocks and wraps continuously.
- Sits between the column decoders and the matrix pins.

Parameters:
- COLS, 5, number of matrix columns (2..8).
- ROWS, 7, number of rows per column.
- DIV, 50000, clocks each column stays active (DIV >= 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  1 = scan matrix, 0 = matrix dark.
- frame_data  input  COLS*ROWS  column images; column c at bits [c*ROWS +: ROWS]; bit r = row r lit.
- rows_out  output  ROWS  row drive, active-high.
- cols_out  output  COLS  column select, active-low, one-cold while scanning.
- col_idx  output  3  index of the currently driven column.
- frame_start  output  1  one-cycle pulse when column 0 of a newly latched frame begins.

Behaviour:
- One clock domain. Reset is synchronous, active-low. All outputs are registered.
- Reset values (rst_n = 0 at a clk edge):
  - state = IDLE, div_cnt = 0, col = 0, shadow = 0.
  - rows_out = 0, cols_out = all 1s, col_idx = 0, frame_start = 0.
- State IDLE:
  - Outputs are off: rows_out = 0, cols_out = all 1s.
  - If enable = 1 in cycle N: at edge N+1, shadow <= frame_data sampled in cycle N, col = 0, div_cnt = 0, state = SCAN, frame_start = 1.
  - From N+1: cols_out = ~(1<<0), rows_out = shadow[ROWS-1:0].
- State SCAN:
  - div_cnt increments each clock, 0..DIV-1.
  - At div_cnt = DIV-1 (terminal count), div_cnt <= 0 and the column advances:
    - col < COLS-1: col <= col+1, shadow is unchanged, frame_start = 0.
    - col = COLS-1: col <= 0, shadow <= frame_data (frame boundary), frame_start = 1 for exactly that cycle.
  - cols_out and rows_out change on the same edge as col, so each column is driven for exactly DIV cycles and a frame lasts COLS*DIV cycles.
- frame_data changes mid-frame have no effect until the next frame boundary (no tearing).
- enable = 0 while in SCAN: next edge goes to IDLE, outputs off, div_cnt = 0, col = 0, frame_start = 0. A later re-enable restarts at column 0 with a fresh latch.
- Reset asserted mid-operation: identical to the reset values above on that edge. No partial column is completed.
- col_idx always equals the registered col and is 0 in IDLE.
- Only one bit of cols_out is ever 0. No cycle has two columns active.

Optional Feature:
- Macro: SCAN_BLANKING_EN.
- Defined:
  - Adds state BLANK. Every terminal count in SCAN goes to BLANK for exactly 1 cycle: cols_out = all 1s, rows_out = 0, col_idx holds the old column.
  - The next edge enters SCAN with the advanced column (and the shadow reload plus frame_start at a frame wrap).
  - Column period becomes DIV+1 clocks; frame period becomes COLS*(DIV+1).
  - enable = 0 or reset during BLANK behaves as in SCAN.
- Undefined: no BLANK state; columns switch back-to-back with no dark cycle.

Test Plan:
- Reset/idle: DIV=4, rst_n=0 for 3 cycles, enable=0 → rows_out=0, cols_out=5'b11111, col_idx=0, frame_start=0, held indefinitely.
- Start and scan: frame_data with col0=7'h41, col1=7'h7F, col2=7'h00, col3=7'h2A, col4=7'h15; enable=1 at cycle N → from N+1 cols_out=5'b11110, rows_out=7'h41 for 4 cycles; then 5'b11101/7'h7F, …, 5'b01111/7'h15; frame_start high only at N+1 and N+21.
- Anti-tear: change frame_data col2 to 7'h55 during column 1 of frame 0 → column 2 still shows 7'h00 in frame 0 and 7'h55 in frame 1.
- Disable mid-scan: deassert enable during column 3 → next cycle rows_out=0, cols_out=all 1s, col_idx=0; re-enable → column 0 with frame_start pulse after 1 cycle.
- Reset mid-scan: rst_n=0 during column 2 → next edge shows all reset values; rst_n=1 with enable=1 → scan restarts at column 0.
- With SCAN_BLANKING_EN, DIV=4: each column active 4 cycles followed by 1 cycle of cols_out=all 1s and rows_out=0; frame_start period = 25 cycles; never two active columns.
